// File: rtl/mau_pkg.sv
// Shared types for the load/store unit: size codes, exception causes, FSM encoding.
// No logic here beyond the alignment rule used at request accept.
package mau_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        CA_OK  = 2'd0,
        CA_MIS = 2'd1,
        CA_MEM = 2'd2,
        CA_TMO = 2'd3
    } cause_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ACC  = 3'd1,
        ST_RD_DONE = 3'd2,
        ST_WR_ACC  = 3'd3,
        ST_WR_DONE = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [1:0]  addr_lo;
        logic [31:0] wdata;
    } req_t;

    // Size code 3 has no legal alignment, so it reports as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mau_lane.sv
// Purpose: byte-lane extract/extend for loads and lane merge for sub-word stores.
// Latency: combinational.
// Backpressure: none; operands are held stable by the owning FSM.
module mau_lane
    import mau_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sext,
    input  logic [31:0] rline,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] mline
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rline[7:0];
        case (addr_lo)
            2'd1:    b = rline[15:8];
            2'd2:    b = rline[23:16];
            2'd3:    b = rline[31:24];
            default: b = rline[7:0];
        endcase
        h = addr_lo[1] ? rline[31:16] : rline[15:0];

        ldata = rline;
        case (size)
            SZ_B:    ldata = {{24{sext & b[7]}}, b};
            SZ_H:    ldata = {{16{sext & h[15]}}, h};
            default: ldata = rline;
        endcase
    end

    always_comb begin
        mline = rline;
        case (size)
            SZ_B: begin
                case (addr_lo)
                    2'd0: mline[7:0]   = wdata[7:0];
                    2'd1: mline[15:8]  = wdata[7:0];
                    2'd2: mline[23:16] = wdata[7:0];
                    2'd3: mline[31:24] = wdata[7:0];
                    default: mline = rline;
                endcase
            end
            SZ_H: begin
                if (addr_lo[1]) mline[31:16] = wdata[15:0];
                else            mline[15:0]  = wdata[15:0];
            end
            default: mline = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: load/store stage driving the word-addressed ram strobe/ready protocol (RMW for sub-word stores).
// Latency: accept + ram cycles + 1 response cycle; misaligned requests respond after 1 cycle.
// Backpressure: req_ready low while a request is outstanding; MAU_TIMEOUT_EN bounds each ram wait.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int TMO_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_cause,
    output logic [31:0] mem_r_addr,
    output logic [31:0] mem_w_addr,
    output logic [31:0] mem_w_line,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_r_line,
    input  logic        mem_rrdy,
    input  logic        mem_wrdy,
    input  logic        mem_exc
);

    state_e      state_q, state_d;
    req_t        req_q;
    logic [31:0] addr_q, w_line_q, rdata_q;
    logic [1:0]  cause_q;
    logic [31:0] lane_ldata, lane_mline;
    logic        accept, misal, in_mem, tmo_hit, abort;

    assign accept = (state_q == ST_IDLE) && req_valid;
    assign misal  = is_misaligned(req_size, req_addr[1:0]);
    assign in_mem = (state_q == ST_RD_ACC) || (state_q == ST_RD_DONE) ||
                    (state_q == ST_WR_ACC) || (state_q == ST_WR_DONE);
    assign abort  = in_mem && (mem_exc || tmo_hit);

    mau_lane u_lane (
        .size    (req_q.size),
        .addr_lo (req_q.addr_lo),
        .sext    (req_q.sext),
        .rline   (mem_r_line),
        .wdata   (req_q.wdata),
        .ldata   (lane_ldata),
        .mline   (lane_mline)
    );

`ifdef MAU_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYCLES) + 1;
    logic [CW-1:0] cnt_q;
    logic          acc_entry;

    assign acc_entry = ((state_d == ST_RD_ACC) || (state_d == ST_WR_ACC)) && (state_d != state_q);
    assign tmo_hit   = in_mem && (cnt_q == CW'(TMO_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst)            cnt_q <= '0;
        else if (acc_entry) cnt_q <= '0;
        else if (in_mem)    cnt_q <= cnt_q + 1'b1;
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Abort (exception or timeout) takes priority over a completion seen in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (misal)                         state_d = ST_RESP;
                    else if (req_we && req_size == SZ_W) state_d = ST_WR_ACC;
                    else                               state_d = ST_RD_ACC;
                end
            end
            ST_RD_ACC: begin
                if (abort)          state_d = ST_RESP;
                else if (!mem_rrdy) state_d = ST_RD_DONE;
            end
            ST_RD_DONE: begin
                if (abort) state_d = ST_RESP;
                else if (mem_rrdy) begin
                    if (req_q.we) state_d = ST_WR_ACC;
                    else          state_d = ST_RESP;
                end
            end
            ST_WR_ACC: begin
                if (abort)          state_d = ST_RESP;
                else if (!mem_wrdy) state_d = ST_WR_DONE;
            end
            ST_WR_DONE: begin
                if (abort)         state_d = ST_RESP;
                else if (mem_wrdy) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        mem_read   = (state_q == ST_RD_ACC) || (state_q == ST_RD_DONE);
        mem_write  = (state_q == ST_WR_ACC) || (state_q == ST_WR_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q    <= '0;
            addr_q   <= '0;
            w_line_q <= '0;
            rdata_q  <= '0;
            cause_q  <= CA_OK;
        end else if (accept) begin
            req_q.we      <= req_we;
            req_q.size    <= req_size;
            req_q.sext    <= req_sext;
            req_q.addr_lo <= req_addr[1:0];
            req_q.wdata   <= req_wdata;
            addr_q        <= {2'b00, req_addr[31:2]};
            w_line_q      <= req_wdata;
            rdata_q       <= '0;
            cause_q       <= misal ? CA_MIS : CA_OK;
        end else if (abort) begin
            cause_q <= mem_exc ? CA_MEM : CA_TMO;
        end else if (state_q == ST_RD_DONE && mem_rrdy) begin
            if (req_q.we) w_line_q <= lane_mline;
            else          rdata_q  <= lane_ldata;
        end
    end

    assign mem_r_addr = addr_q;
    assign mem_w_addr = addr_q;
    assign mem_w_line = w_line_q;
    assign resp_rdata = rdata_q;
    assign resp_cause = cause_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural ram model; timeout checks follow MAU_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_sext;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_cause;
    logic [31:0] mem_r_addr, mem_w_addr, mem_w_line, mem_r_line;
    logic        mem_read, mem_write, mem_rrdy, mem_wrdy, mem_exc;

    mem_access_unit #(.TMO_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_cause(resp_cause),
        .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr), .mem_w_line(mem_w_line),
        .mem_read(mem_read), .mem_write(mem_write), .mem_r_line(mem_r_line),
        .mem_rrdy(mem_rrdy), .mem_wrdy(mem_wrdy), .mem_exc(mem_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ram model: rrdy/wrdy idle high, drop one cycle after the strobe is seen, return when not held.
    logic [31:0] mem [0:63];
    int  rph, wph, rd_cnt, wr_cnt, rd_hi;
    logic rd_stall, wr_hold;

    always @(posedge clk) begin
        if (rst) begin
            mem_rrdy <= 1'b1; mem_wrdy <= 1'b1; mem_r_line <= '0; rph <= 0; wph <= 0;
        end else begin
            case (rph)
                0: if (mem_read) begin mem_rrdy <= 1'b0; rph <= 1; rd_cnt <= rd_cnt + 1; end
                1: if (!rd_stall) begin mem_rrdy <= 1'b1; mem_r_line <= mem[mem_r_addr[5:0]]; rph <= 2; end
                default: rph <= 0;
            endcase
            case (wph)
                0: if (mem_write) begin mem_wrdy <= 1'b0; wph <= 1; wr_cnt <= wr_cnt + 1; end
                1: if (!wr_hold) begin mem_wrdy <= 1'b1; mem[mem_w_addr[5:0]] <= mem_w_line; wph <= 2; end
                default: wph <= 0;
            endcase
        end
    end

    always @(negedge clk) if (mem_read) rd_hi++;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  cause;
        string       tag;
    } exp_t;
    exp_t exp_q[$];
    int   resp_cnt = 0;

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_resp: got rdata=%h cause=%0d expected no response", resp_rdata, resp_cause);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, "_rdata"}, resp_rdata, e.rdata);
                check({e.tag, "_cause"}, 32'(resp_cause), 32'(e.cause));
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] xr, input logic [1:0] xc, input string tag, input bit push);
        int n = 0;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_sext = sext;
        req_addr = addr; req_wdata = wdata;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL %s_accept: req_ready stayed 0 for %0d cycles, required 1", tag, n);
        end
        if (push) begin
            e.rdata = xr; e.cause = xc; e.tag = tag;
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL %s_drain: %0d responses still pending after %0d cycles, required 0", tag, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic wait_low(input bit wr, input string tag);
        int n = 0;
        while ((wr ? mem_wrdy : mem_rrdy) && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL %s_rdy_low: ready stayed 1 for %0d cycles, required 0", tag, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    int r0, w0;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sext = 1'b0;
        req_addr = '0; req_wdata = '0; mem_exc = 1'b0; rd_stall = 1'b0; wr_hold = 1'b0;
        rd_cnt = 0; wr_cnt = 0; rd_hi = 0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_read",   32'(mem_read),   32'd0);
        check("rst_mem_write",  32'(mem_write),  32'd0);
        check("rst_mem_r_addr", mem_r_addr, 32'd0);
        check("rst_mem_w_addr", mem_w_addr, 32'd0);
        check("rst_mem_w_line", mem_w_line, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_cause", 32'(resp_cause), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // word store then load
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 2'd0, "sw10", 1'b1);
        check("sw10_strobe", 32'(mem_write), 32'd1);
        check("sw10_w_addr", mem_w_addr, 32'd4);
        check("sw10_w_line", mem_w_line, 32'hDEADBEEF);
        drain("sw10");
        check("sw10_mem", mem[4], 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2'd0, "lw10", 1'b1);
        check("lw10_r_addr", mem_r_addr, 32'd4);
        drain("lw10");

        // byte store read-modify-write, then byte loads
        mem[4] = 32'h11223344;
        r0 = rd_cnt; w0 = wr_cnt;
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AA, 32'h0, 2'd0, "sb13", 1'b1);
        drain("sb13");
        check("sb13_rmw_reads",  32'(rd_cnt - r0), 32'd1);
        check("sb13_rmw_writes", 32'(wr_cnt - w0), 32'd1);
        check("sb13_mem", mem[4], 32'hAA223344);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h000000AA, 2'd0, "lbu13", 1'b1);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'hFFFFFFAA, 2'd0, "lb13", 1'b1);
        issue(1'b1, 2'd1, 1'b0, 32'h10, 32'hFFFFBEEF, 32'h0, 2'd0, "sh10", 1'b1);
        drain("sh10");
        check("sh10_mem", mem[4], 32'hAA22BEEF);
        issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h0000AA22, 2'd0, "lhu12", 1'b1);
        drain("lhu12");

        // half loads with extension, misaligned requests
        mem[4] = 32'h80017FFF;
        issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'hFFFF8001, 2'd0, "lh12", 1'b1);
        issue(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h00007FFF, 2'd0, "lh10", 1'b1);
        issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'h0000007F, 2'd0, "lb11", 1'b1);
        drain("lhx");
        r0 = rd_cnt; w0 = wr_cnt;
        issue(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 32'h0, 2'd1, "lw06", 1'b1);
        issue(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 32'h0, 2'd1, "sz3", 1'b1);
        issue(1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, 32'h0, 2'd1, "sh11", 1'b1);
        drain("mis");
        check("mis_no_read",  32'(rd_cnt - r0), 32'd0);
        check("mis_no_write", 32'(wr_cnt - w0), 32'd0);

        // memory exception in RD_DONE
        rd_stall = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 2'd2, "exc", 1'b1);
        wait_low(1'b0, "exc");
        @(posedge clk); #1;
        check("exc_rd_done_strobe", 32'(mem_read), 32'd1);
        mem_exc = 1'b1;
        @(posedge clk); #1;
        mem_exc = 1'b0;
        check("exc_strobe_drop", 32'(mem_read), 32'd0);
        drain("exc");
        rd_stall = 1'b0;
        repeat (4) @(posedge clk);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80017FFF, 2'd0, "after_exc", 1'b1);
        drain("after_exc");

        // ram never returns ready
        rd_stall = 1'b1;
`ifdef MAU_TIMEOUT_EN
        rd_hi = 0;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 2'd3, "tmo", 1'b1);
        drain("tmo");
        check("tmo_wait_cycles", 32'(rd_hi), 32'd8);
`else
        r0 = resp_cnt;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 2'd0, "hang", 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("hang_no_resp", 32'(resp_cnt - r0), 32'd0);
        check("hang_strobe_held", 32'(mem_read), 32'd1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
`endif
        rd_stall = 1'b0;
        repeat (4) @(posedge clk);

        // reset while the write is outstanding
        wr_hold = 1'b1;
        r0 = resp_cnt;
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, 32'h0, 2'd0, "rstwr", 1'b0);
        wait_low(1'b1, "rstwr");
        @(posedge clk); #1;
        check("rstwr_in_done", 32'(mem_write), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstwr_write",     32'(mem_write),  32'd0);
        check("rstwr_read",      32'(mem_read),   32'd0);
        check("rstwr_req_ready", 32'(req_ready),  32'd1);
        check("rstwr_resp",      32'(resp_valid), 32'd0);
        check("rstwr_w_addr",    mem_w_addr,      32'd0);
        @(negedge clk); rst = 1'b0; wr_hold = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rstwr_no_resp", 32'(resp_cnt - r0), 32'd0);
        check("rstwr_mem", mem[8], 32'd0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h80017FFF, 2'd0, "after_rst", 1'b1);
        drain("after_rst");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
